trees_job_sched: RTL and testbench
==================================

Name: trees_job_sched

Overview:
- Job scheduler that shares one tree-ensemble ping-pong accelerator between N_REQ requesters.
- Round-robin arbitration selects one job at a time. The granted requester's feature words stream into accelerator feature memory, then the block pulses start and waits for done.
- Packed prediction words then stream back, tagged with the requester id.
- Sits between the requester-side stream fabric and the accelerator's load/start/read port.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- N_FEATURE, 32, features per sample (even); feature words per sample = N_FEATURE/2.
- MAX_BURST, 5000, maximum samples per job.
- TO_CYCLES, 1048576, watchdog limit in RUN (only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  job request per requester.
- req_burst_len  in  N_REQ*BL_W  samples per job, BL_W=$clog2(MAX_BURST)+1.
- req_ready  out  N_REQ  one-hot job-accept strobe.
- in_valid  in  N_REQ  feature-word valid per requester.
- in_data  in  N_REQ*64  feature words, two 32-bit features each.
- in_ready  out  N_REQ  feature-word ready; only the granted bit may be high.
- res_valid  out  1  prediction word valid.
- res_data  out  64  eight 8-bit predictions, sample k in byte k%8.
- res_last  out  1  last word of job.
- res_id  out  $clog2(N_REQ)  owning requester.
- res_ready  in  1  downstream ready.
- job_err  out  1  one-cycle pulse: rejected or timed-out job.
- acc_load_features  out  1  feature write enable.
- acc_feature_addr  out  $clog2(MAX_BURST*N_FEATURE/2)  feature word address.
- acc_features2  out  64  feature word.
- acc_burst_len  out  BL_W  job length, held stable from START through DRAIN.
- acc_start  out  1  one-cycle start pulse.
- acc_done  in  1  one-cycle completion pulse.
- acc_prediction_addr  out  BL_W  prediction word address.
- acc_prediction  in  64  prediction word, combinational read of acc_prediction_addr.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; rr pointer 0.
  - A reset mid-job aborts silently: no res_last, no job_err.
  - The accelerator is reset by the same system reset; the scheduler must never pulse acc_start without a preceding reset or acc_done.
- States: IDLE → ARB → LOAD → START → RUN → DRAIN → IDLE.
- IDLE/ARB:
  - Pick the first asserted req_valid at or after the rr pointer.
  - Assert req_ready for that bit for exactly one cycle.
  - Latch gid and burst_len; set rr = gid+1 mod N_REQ.
  - With no request, stay in IDLE.
- Rejection:
  - Condition: latched burst_len==0 or burst_len>MAX_BURST.
  - The job is accepted, job_err pulses the next cycle, and the block returns to IDLE.
  - No accelerator activity, no result beats.
- LOAD:
  - in_ready[gid]=1. Each in_valid&in_ready beat drives acc_load_features=1, acc_features2=data, acc_feature_addr=wcnt (same cycle), then wcnt++.
  - Leaves after wcnt reaches burst_len*N_FEATURE/2. The product is computed at full width with no truncation.
- START: acc_start=1 for one cycle, then RUN.
- RUN: wait for acc_done. A done arriving in any other state is ignored.
- DRAIN:
  - Words = ceil(burst_len/8). acc_prediction_addr=rcnt; res_data=acc_prediction; res_valid=1; res_id=gid.
  - res_last=1 when rcnt==words-1.
  - rcnt advances only on res_valid&res_ready. res_data, res_id and res_last stay stable while stalled.
  - After the last handshake, return to IDLE. The next job may be granted the following cycle.
- Partial last word: unused bytes pass through unmodified, with no masking.
- New requests are not accepted while a job is active. req_ready stays 0 outside ARB.

Optional Feature:
- Macro: TREES_SCHED_TIMEOUT_EN.
- With it:
  - A counter runs in RUN. If it reaches TO_CYCLES without acc_done, job_err pulses, no results are emitted, and the block returns to IDLE.
  - The accelerator is not restarted until a late acc_done is seen; a sticky wait_done flag blocks ARB.
- Without it: RUN waits indefinitely; job_err is driven only by rejection.

Decomposition:
- Package trees_sched_pkg holds:
  - the state enum;
  - BL_W, word-count and address-width localparam functions;
  - a ceil_div8 function.
- Sub-module rr_arbiter (N_REQ; req, advance, grant one-hot, grant index) handles round-robin selection.
- FSM, counters and stream muxing stay in trees_job_sched.

Test Plan:
- Requester 0, burst_len=3, 48 words → 48 acc_load_features beats, addr 0..47, one acc_start, then after acc_done one res beat with res_last=1 and res_id=0.
- Both requesters valid from reset → grant order 0,1,0,1 across four jobs; req_ready is one-hot each time.
- burst_len=17 with res_ready toggling every other cycle → 3 result words, addr 0,1,2, data stable during stalls, res_last only on word 2.
- burst_len=0 and burst_len=5001 → job_err pulse each time, no acc_start, no res_valid, next job served normally.
- rst asserted during LOAD at word 10 → all outputs 0 the next cycle; a fresh job afterwards restarts at addr 0.
- Timeout build with TO_CYCLES=100 and acc_done withheld → job_err at cycle 100 of RUN, no results; ARB stays blocked until acc_done arrives.

Source files
------------

// File: rtl/trees_sched_pkg.sv
// Shared types and sizing helpers for the tree-ensemble job scheduler.
package trees_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_RUN   = 3'd4,
        ST_DRAIN = 3'd5
    } state_e;

    // Width of a burst-length field: must hold MAX_BURST itself plus out-of-range values.
    function automatic int bl_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    // Width of the accelerator feature-memory address.
    function automatic int feat_addr_width(input int max_burst, input int n_feature);
        return $clog2(max_burst * n_feature / 2);
    endfunction

    // Width of the feature-word counter: wide enough for burst_len * N_FEATURE/2 untruncated.
    function automatic int wcnt_width(input int max_burst, input int n_feature);
        return bl_width(max_burst) + $clog2(n_feature);
    endfunction

    // Number of 64-bit prediction words needed for n one-byte predictions.
    function automatic logic [31:0] ceil_div8(input logic [31:0] n);
        return (n + 32'd7) >> 3;
    endfunction

endpackage

// File: rtl/trees_job_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the rotating pointer.
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             advance_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IW-1:0]    grant_idx_o,
    output logic             any_o
);

    logic [IW-1:0] ptr_q;

    // Scan requests starting at the pointer and pick the first asserted one.
    always_comb begin
        grant_idx_o = '0;
        any_o       = 1'b0;
        grant_o     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_o && req_i[(int'(ptr_q) + i) % N_REQ]) begin
                any_o       = 1'b1;
                grant_idx_o = IW'((int'(ptr_q) + i) % N_REQ);
            end else begin
                any_o = any_o;
            end
        end
        if (any_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end else begin
            grant_o = '0;
        end
    end

    // Move the pointer just past the winner whenever a grant is consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (advance_i && any_o) begin
            ptr_q <= (grant_idx_o == IW'(N_REQ - 1)) ? '0 : grant_idx_o + IW'(1);
        end
    end

endmodule

// File: rtl/trees_job_sched.sv
// Job scheduler sharing one tree-ensemble accelerator among N_REQ requesters.
// Optional RUN watchdog enabled by defining TREES_SCHED_TIMEOUT_EN.
module trees_job_sched
    import trees_sched_pkg::*;
#(
    parameter  int N_REQ     = 2,
    parameter  int N_FEATURE = 32,
    parameter  int MAX_BURST = 5000,
    parameter  int TO_CYCLES = 1048576,
    localparam int BL_W      = bl_width(MAX_BURST),
    localparam int AW        = feat_addr_width(MAX_BURST, N_FEATURE),
    localparam int IW        = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*BL_W-1:0]   req_burst_len,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ*64-1:0]     in_data,
    output logic [N_REQ-1:0]        in_ready,
    output logic                    res_valid,
    output logic [63:0]             res_data,
    output logic                    res_last,
    output logic [IW-1:0]           res_id,
    input  logic                    res_ready,
    output logic                    job_err,
    output logic                    acc_load_features,
    output logic [AW-1:0]           acc_feature_addr,
    output logic [63:0]             acc_features2,
    output logic [BL_W-1:0]         acc_burst_len,
    output logic                    acc_start,
    input  logic                    acc_done,
    output logic [BL_W-1:0]         acc_prediction_addr,
    input  logic [63:0]             acc_prediction
);

    localparam int WT  = wcnt_width(MAX_BURST, N_FEATURE);
    localparam int WPS = N_FEATURE / 2;

    state_e            state_q, state_d;
    logic [IW-1:0]     gid_q;
    logic [BL_W-1:0]   bl_q;
    logic [WT-1:0]     wcnt_q;
    logic [BL_W-1:0]   rcnt_q;
    logic              job_err_q;

    logic [N_REQ-1:0]  grant_s;
    logic [IW-1:0]     grant_idx_s;
    logic              any_s;
    logic              arb_take_s;
    logic [BL_W-1:0]   cand_len_s;
    logic              cand_bad_s;
    logic [WT-1:0]     wtot_s;
    logic [BL_W-1:0]   words_s;
    logic              beat_s;
    logic              last_beat_s;
    logic              drain_hs_s;
    logic              last_word_s;
    logic              to_hit_s;
    logic              wait_done_s;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req_valid),
        .advance_i   (arb_take_s),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s),
        .any_o       (any_s)
    );

`ifdef TREES_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES) + 1;
    logic [TW-1:0] to_cnt_q;
    logic          wait_done_q;

    assign to_hit_s    = (state_q == ST_RUN) && !acc_done && (to_cnt_q == TW'(TO_CYCLES - 1));
    assign wait_done_s = wait_done_q;

    // Count cycles spent in RUN; cleared in every other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q != ST_RUN) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    // After a timeout, hold off new jobs until the accelerator reports its late done.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_done_q <= 1'b0;
        end else if (acc_done) begin
            wait_done_q <= 1'b0;
        end else if (to_hit_s) begin
            wait_done_q <= 1'b1;
        end
    end
`else
    assign to_hit_s    = 1'b0;
    assign wait_done_s = 1'b0;
`endif

    // Decode handshakes, job sizes and counter end conditions.
    always_comb begin
        arb_take_s  = (state_q == ST_ARB) && any_s;
        cand_len_s  = req_burst_len[int'(grant_idx_s)*BL_W +: BL_W];
        cand_bad_s  = (cand_len_s == '0) || (cand_len_s > BL_W'(MAX_BURST));
        wtot_s      = WT'(bl_q) * WT'(WPS);
        words_s     = BL_W'(ceil_div8(32'(bl_q)));
        beat_s      = (state_q == ST_LOAD) && in_valid[gid_q];
        last_beat_s = beat_s && (wcnt_q == wtot_s - WT'(1));
        drain_hs_s  = (state_q == ST_DRAIN) && res_ready;
        last_word_s = (rcnt_q == words_s - BL_W'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the job lifecycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_s && !wait_done_s) state_d = ST_ARB;    else state_d = ST_IDLE;
            ST_ARB:   if (!any_s || cand_bad_s)  state_d = ST_IDLE;   else state_d = ST_LOAD;
            ST_LOAD:  if (last_beat_s)           state_d = ST_START;  else state_d = ST_LOAD;
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (acc_done)      state_d = ST_DRAIN;
                else if (to_hit_s) state_d = ST_IDLE;
                else               state_d = ST_RUN;
            end
            ST_DRAIN: if (drain_hs_s && last_word_s) state_d = ST_IDLE; else state_d = ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Job context, feature/result counters and the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            gid_q     <= '0;
            bl_q      <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            job_err_q <= 1'b0;
        end else begin
            job_err_q <= to_hit_s || (arb_take_s && cand_bad_s);
            if (arb_take_s) begin
                gid_q  <= grant_idx_s;
                bl_q   <= cand_len_s;
                wcnt_q <= '0;
                rcnt_q <= '0;
            end else begin
                if (beat_s) begin
                    wcnt_q <= wcnt_q + WT'(1);
                end
                if (drain_hs_s) begin
                    rcnt_q <= rcnt_q + BL_W'(1);
                end
            end
        end
    end

    // Drive requester, result and accelerator ports from the current state.
    always_comb begin
        req_ready           = '0;
        in_ready            = '0;
        res_valid           = 1'b0;
        res_data            = 64'd0;
        res_last            = 1'b0;
        res_id              = '0;
        acc_load_features   = 1'b0;
        acc_feature_addr    = '0;
        acc_features2       = 64'd0;
        acc_start           = 1'b0;
        acc_prediction_addr = '0;
        job_err             = job_err_q;
        acc_burst_len       = bl_q;
        case (state_q)
            ST_ARB: req_ready = grant_s;
            ST_LOAD: begin
                in_ready[gid_q]   = 1'b1;
                acc_load_features = in_valid[gid_q];
                acc_feature_addr  = wcnt_q[AW-1:0];
                acc_features2     = in_data[int'(gid_q)*64 +: 64];
            end
            ST_START: acc_start = 1'b1;
            ST_DRAIN: begin
                res_valid           = 1'b1;
                res_data            = acc_prediction;
                res_last            = last_word_s;
                res_id              = gid_q;
                acc_prediction_addr = rcnt_q;
            end
            default: req_ready = '0;
        endcase
    end

endmodule

// File: tb/tb_trees_job_sched.sv
// Directed self-checking bench for trees_job_sched (default build).
module tb_trees_job_sched;

    localparam int N_REQ = 2;
    localparam int BL_W  = 14;
    localparam int AW    = 17;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*BL_W-1:0] req_burst_len;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      in_valid;
    logic [N_REQ*64-1:0]   in_data;
    logic [N_REQ-1:0]      in_ready;
    logic                  res_valid;
    logic [63:0]           res_data;
    logic                  res_last;
    logic [0:0]            res_id;
    logic                  res_ready;
    logic                  job_err;
    logic                  acc_load_features;
    logic [AW-1:0]         acc_feature_addr;
    logic [63:0]           acc_features2;
    logic [BL_W-1:0]       acc_burst_len;
    logic                  acc_start;
    logic                  acc_done;
    logic [BL_W-1:0]       acc_prediction_addr;
    logic [63:0]           acc_prediction;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int n_load = 0;
    int n_res = 0;
    int n_jerr = 0;

    always #5 clk = ~clk;

    assign acc_prediction = {32'hCAFE_0000, 18'h0, acc_prediction_addr};

    trees_job_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_burst_len(req_burst_len), .req_ready(req_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
        .res_id(res_id), .res_ready(res_ready), .job_err(job_err),
        .acc_load_features(acc_load_features), .acc_feature_addr(acc_feature_addr),
        .acc_features2(acc_features2), .acc_burst_len(acc_burst_len),
        .acc_start(acc_start), .acc_done(acc_done),
        .acc_prediction_addr(acc_prediction_addr), .acc_prediction(acc_prediction)
    );

    // Event counters observed at each active edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (acc_start)             n_start <= n_start + 1;
            if (acc_load_features)     n_load  <= n_load + 1;
            if (res_valid && res_ready) n_res  <= n_res + 1;
            if (job_err)               n_jerr  <= n_jerr + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] onehot(input int r);
        return 64'd1 << r;
    endfunction

    function automatic logic [63:0] pat(input int r, input int w);
        return {8'(r), 24'h5A5A5A, 32'(w)};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({req_ready, in_ready, res_valid, res_last, res_id,
                                job_err, acc_load_features, acc_start}), 64'd0);
        chk({tag, "_res"}, res_data, 64'd0);
        chk({tag, "_feat"}, acc_features2, 64'd0);
        chk({tag, "_addr"}, 64'({acc_feature_addr, acc_burst_len, acc_prediction_addr}), 64'd0);
    endtask

    // Wait (bounded) for the job-accept strobe and check it selects r_exp only.
    task automatic accept(input int r_exp);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (req_ready != '0) got = 1'b1;
        end
        chk("req_ready_onehot", 64'(req_ready), onehot(r_exp));
    endtask

    task automatic load(input int r, input int nbeats);
        for (int w = 0; w < nbeats; w++) begin
            if (w == 5) begin
                in_valid = '0;
                #1;
                chk("load_gap", 64'(acc_load_features), 64'd0);
                tick();
            end
            in_valid = '0;
            in_valid[r] = 1'b1;
            in_data[r*64 +: 64] = pat(r, w);
            #1;
            chk("load_en", 64'(acc_load_features), 64'd1);
            chk("load_addr", 64'(acc_feature_addr), 64'(w));
            chk("load_data", acc_features2, pat(r, w));
            chk("in_ready", 64'(in_ready), onehot(r));
            chk("req_ready_busy", 64'(req_ready), 64'd0);
            tick();
        end
        in_valid = '0;
    endtask

    task automatic startrun(input int len);
        chk("acc_start", 64'(acc_start), 64'd1);
        chk("acc_burst_len", 64'(acc_burst_len), 64'(len));
        tick();
        chk("acc_start_pulse", 64'(acc_start), 64'd0);
        repeat (3) begin
            tick();
            chk("run_no_res", 64'(res_valid), 64'd0);
        end
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
    endtask

    task automatic drain(input int r, input int len, input bit stall);
        int words = (len + 7) / 8;
        logic [63:0] exp;
        for (int k = 0; k < words; k++) begin
            exp = {32'hCAFE_0000, 18'h0, 14'(k)};
            if (stall) begin
                res_ready = 1'b0;
                #1;
                chk("stall_valid", 64'(res_valid), 64'd1);
                chk("stall_data", res_data, exp);
                tick();
                chk("stall_hold_data", res_data, exp);
                chk("stall_hold_last", 64'(res_last), 64'(k == words - 1));
                chk("stall_hold_id", 64'(res_id), 64'(r));
            end
            res_ready = 1'b1;
            #1;
            chk("res_valid", 64'(res_valid), 64'd1);
            chk("res_data", res_data, exp);
            chk("res_last", 64'(res_last), 64'(k == words - 1));
            chk("res_id", 64'(res_id), 64'(r));
            chk("pred_addr", 64'(acc_prediction_addr), 64'(k));
            chk("burst_hold", 64'(acc_burst_len), 64'(len));
            tick();
        end
        res_ready = 1'b0;
        chk("drain_end", 64'(res_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, l0, r0, j0;
        rst = 1'b1;
        req_valid = '0;
        req_burst_len = '0;
        in_valid = '0;
        in_data = '0;
        res_ready = 1'b0;
        acc_done = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // A done outside RUN is ignored.
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        tick();
        chk("stray_done", 64'({res_valid, acc_start, req_ready}), 64'd0);

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        req_burst_len = {14'd1, 14'd1};
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            accept(j % 2);
            tick();
            load(j % 2, 16);
            startrun(1);
            drain(j % 2, 1, 1'b0);
        end
        req_valid = '0;

        // Requester 0, three samples: 48 feature words, one result word.
        s0 = n_start; l0 = n_load; r0 = n_res;
        req_burst_len[BL_W-1:0] = 14'd3;
        req_valid = 2'b01;
        accept(0);
        tick();
        req_valid = '0;
        load(0, 48);
        startrun(3);
        drain(0, 3, 1'b0);
        chk("job3_loads", 64'(n_load - l0), 64'd48);
        chk("job3_starts", 64'(n_start - s0), 64'd1);
        chk("job3_results", 64'(n_res - r0), 64'd1);

        // Requester 1, 17 samples with a stalled result stream.
        req_burst_len[2*BL_W-1:BL_W] = 14'd17;
        req_valid = 2'b10;
        accept(1);
        tick();
        req_valid = '0;
        load(1, 272);
        startrun(17);
        drain(1, 17, 1'b1);

        // Rejected lengths: 0 and MAX_BURST+1.
        s0 = n_start; l0 = n_load; r0 = n_res; j0 = n_jerr;
        req_burst_len[BL_W-1:0] = 14'd0;
        req_valid = 2'b01;
        accept(0);
        tick();
        chk("rej0_err", 64'(job_err), 64'd1);
        req_valid = '0;
        tick();
        chk("rej0_err_pulse", 64'(job_err), 64'd0);
        req_burst_len[2*BL_W-1:BL_W] = 14'd5001;
        req_valid = 2'b10;
        accept(1);
        tick();
        chk("rej5001_err", 64'(job_err), 64'd1);
        req_valid = '0;
        tick();
        chk("rej5001_err_pulse", 64'(job_err), 64'd0);
        repeat (3) tick();
        chk("rej_no_start", 64'(n_start - s0), 64'd0);
        chk("rej_no_load", 64'(n_load - l0), 64'd0);
        chk("rej_no_res", 64'(n_res - r0), 64'd0);
        chk("rej_err_count", 64'(n_jerr - j0), 64'd2);

        // Next job after rejections, exactly one full word.
        req_burst_len[BL_W-1:0] = 14'd8;
        req_valid = 2'b01;
        accept(0);
        tick();
        req_valid = '0;
        load(0, 128);
        startrun(8);
        drain(0, 8, 1'b0);

        // Reset in the middle of LOAD at word 10, then a fresh job.
        j0 = n_jerr; r0 = n_res;
        req_burst_len[BL_W-1:0] = 14'd2;
        req_valid = 2'b01;
        accept(0);
        tick();
        req_valid = '0;
        load(0, 10);
        in_valid[0] = 1'b1;
        in_data[63:0] = pat(0, 10);
        rst = 1'b1;
        tick();
        chk_reset_outputs("midload_rst");
        rst = 1'b0;
        in_valid = '0;
        tick();
        chk("midload_no_err", 64'(n_jerr - j0), 64'd0);
        chk("midload_no_res", 64'(n_res - r0), 64'd0);
        req_burst_len[2*BL_W-1:BL_W] = 14'd1;
        req_valid = 2'b10;
        accept(1);
        tick();
        req_valid = '0;
        load(1, 16);
        startrun(1);
        drain(1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
